// File: rtl/lenet_fc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lenet_fc_pkg
// Brief  : Shared constants and one-hot FSM encoding for the LeNet-5 L5 FC engine
// Rev    : 1.0
// ----------------------------------------------------------------------------
package lenet_fc_pkg;

  localparam int L5_FEATURES = 400;
  localparam int BANK_DEPTH  = 200;
  localparam int NEURONS     = 120;
  localparam int SAT_MAX     = 2047;
  localparam int SAT_MIN     = -2048;

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    BIAS  = 6'b000010,
    MAC   = 6'b000100,
    DRAIN = 6'b001000,
    WRITE = 6'b010000,
    DONE  = 6'b100000
  } fc5_state_e;

endpackage
`default_nettype wire

// File: rtl/fc5_mac_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fc5_mac_unit
// Brief  : Dual-product MAC with bias preload and shift/saturate output; FC5_RELU_EN clamps negatives to 0
// Rev    : 1.0
// ----------------------------------------------------------------------------
module fc5_mac_unit
  import lenet_fc_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int FRAC_BITS  = 6,
  parameter int ACC_WIDTH  = 32,
  parameter int READ_LAT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         valid_i,
  input  logic                         bias_load_i,
  input  logic signed [DATA_WIDTH-1:0] bias_i,
  input  logic signed [DATA_WIDTH-1:0] data1_i,
  input  logic signed [DATA_WIDTH-1:0] data2_i,
  input  logic signed [DATA_WIDTH-1:0] weight_a_i,
  input  logic signed [DATA_WIDTH-1:0] weight_b_i,
  input  logic                         result_load_i,
  output logic        [DATA_WIDTH-1:0] result_o
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(SAT_MAX);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(SAT_MIN);

  logic        [READ_LAT-1:0]     vld_q;
  logic signed [2*DATA_WIDTH-1:0] p1_q, p2_q;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [DATA_WIDTH-1:0]   res_q, res_d, sat;
  logic signed [ACC_WIDTH-1:0]    bias_ext, shifted;

  assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_i[DATA_WIDTH-1]}}, bias_i};

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      vld_q <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      vld_q <= (vld_q << 1) | READ_LAT'(valid_i);
      p1_q  <= data1_i * weight_a_i;
      p2_q  <= data2_i * weight_b_i;
      // Bias is placed at the product scale (2*FRAC_BITS) so the final shift treats it like a product.
      if (bias_load_i)
        acc_q <= bias_ext <<< FRAC_BITS;
      else if (vld_q[READ_LAT-1])
        acc_q <= acc_q + ACC_WIDTH'(p1_q) + ACC_WIDTH'(p2_q);
      if (result_load_i)
        res_q <= res_d;
    end
  end

  always_comb begin
    shifted = acc_q >>> FRAC_BITS;
    if (shifted > SAT_HI)
      sat = DATA_WIDTH'(SAT_MAX);
    else if (shifted < SAT_LO)
      sat = DATA_WIDTH'(SAT_MIN);
    else
      sat = shifted[DATA_WIDTH-1:0];
`ifdef FC5_RELU_EN
    res_d = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    res_d = sat;
`endif
  end

  assign result_o = res_q;

endmodule
`default_nettype wire

// File: rtl/fc_layer5_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fc_layer5_engine
// Brief  : LeNet-5 layer-5 FC stage (120 neurons x 400 inputs, 2 MACs/cycle); FC5_RELU_EN fuses ReLU
// Rev    : 1.0
// ----------------------------------------------------------------------------
module fc_layer5_engine
  import lenet_fc_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int FRAC_BITS  = 6,
  parameter int ACC_WIDTH  = 32,
  parameter int READ_LAT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         L5_en,
  output logic                  [7:0]  L4_read_addr,
  input  logic signed [DATA_WIDTH-1:0] L4_read_data1,
  input  logic signed [DATA_WIDTH-1:0] L4_read_data2,
  output logic                 [15:0]  L5_weight_addra,
  output logic                 [15:0]  L5_weight_addrb,
  input  logic signed [DATA_WIDTH-1:0] L5_weight_douta,
  input  logic signed [DATA_WIDTH-1:0] L5_weight_doutb,
  output logic                  [6:0]  L5_bias_addr,
  input  logic signed [DATA_WIDTH-1:0] L5_bias_dout,
  output logic                  [6:0]  L5_output_write_addr,
  output logic        [DATA_WIDTH-1:0] L5_output_write_data,
  output logic                         L5_output_wea,
  output logic                  [6:0]  neuron_count,
  output logic                         L5_done
);

  localparam int LAT_W = $clog2(READ_LAT + 1);

  fc5_state_e       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [7:0]       idx_q, idx_d;
  logic [15:0]      addra_q, addra_d, addrb_q, addrb_d, base_q, base_d;
  logic [6:0]       ncnt_q, ncnt_d;
  logic             bias_load, res_load, clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      idx_q   <= '0;
      addra_q <= '0;
      addrb_q <= '0;
      base_q  <= '0;
      ncnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      addra_q <= addra_d;
      addrb_q <= addrb_d;
      base_q  <= base_d;
      ncnt_q  <= ncnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    idx_d     = idx_q;
    addra_d   = addra_q;
    addrb_d   = addrb_q;
    base_d    = base_q;
    ncnt_d    = ncnt_q;
    bias_load = 1'b0;
    res_load  = 1'b0;
    clr       = 1'b0;
    if (state_q != IDLE && !L5_en) begin
      state_d = IDLE;
      lat_d   = '0;
      idx_d   = '0;
      addra_d = '0;
      addrb_d = '0;
      base_d  = '0;
      ncnt_d  = '0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (L5_en) begin
          state_d = BIAS;
          lat_d   = '0;
        end
        BIAS: if (lat_q == LAT_W'(READ_LAT - 1)) begin
          // Addresses leave registered, so the first MAC address is loaded here.
          bias_load = 1'b1;
          lat_d     = '0;
          idx_d     = '0;
          addra_d   = base_q;
          addrb_d   = base_q + 16'(BANK_DEPTH);
          state_d   = MAC;
        end else begin
          lat_d = lat_q + 1'b1;
        end
        MAC: if (idx_q == 8'(BANK_DEPTH - 1)) begin
          state_d = DRAIN;
        end else begin
          idx_d   = idx_q + 8'd1;
          addra_d = addra_q + 16'd1;
          addrb_d = addrb_q + 16'd1;
        end
        DRAIN: if (lat_q == LAT_W'(READ_LAT)) begin
          res_load = 1'b1;
          lat_d    = '0;
          state_d  = WRITE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
        WRITE: if (ncnt_q == 7'(NEURONS - 1)) begin
          state_d = DONE;
        end else begin
          ncnt_d  = ncnt_q + 7'd1;
          base_d  = base_q + 16'(L5_FEATURES);
          state_d = BIAS;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  fc5_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH),
    .READ_LAT   (READ_LAT)
  ) u_mac (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clr),
    .valid_i       (state_q == MAC),
    .bias_load_i   (bias_load),
    .bias_i        (L5_bias_dout),
    .data1_i       (L4_read_data1),
    .data2_i       (L4_read_data2),
    .weight_a_i    (L5_weight_douta),
    .weight_b_i    (L5_weight_doutb),
    .result_load_i (res_load),
    .result_o      (L5_output_write_data)
  );

  assign L4_read_addr         = idx_q;
  assign L5_weight_addra      = addra_q;
  assign L5_weight_addrb      = addrb_q;
  assign L5_bias_addr         = ncnt_q;
  assign L5_output_write_addr = ncnt_q;
  assign neuron_count         = ncnt_q;
  assign L5_output_wea        = (state_q == WRITE);
  assign L5_done              = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_fc_layer5_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_fc_layer5_engine
// Brief  : Directed self-checking bench for fc_layer5_engine with behavioural L4/weight/bias memories
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_fc_layer5_engine;

  logic               clk = 1'b0;
  logic               rst, L5_en;
  logic        [7:0]  L4_read_addr;
  logic signed [11:0] d1, d2, wa_dout, wb_dout, bias_dout;
  logic        [15:0] addra, addrb;
  logic        [6:0]  bias_addr, wr_addr, neuron_count;
  logic        [11:0] wr_dat;
  logic               wea, L5_done;

  int checks = 0;
  int failures = 0;
  int f_val = 0, wa_val = 0, wb_val = 0;
  int run_id = 0;
  bit mon_en = 1'b0;
  int addr_bad = 0;
  int mon_idx;
  logic signed [11:0] bias_mem [0:119];
  logic signed [11:0] wr_data  [0:127];
  int wr_tag   [0:127] = '{default: -1};
  int wr_count [0:15]  = '{default: 0};
  bit addr_seen [0:199] = '{default: 1'b0};

`ifdef FC5_RELU_EN
  localparam int EXP_NEG = 0;
`else
  localparam int EXP_NEG = -2048;
`endif

  fc_layer5_engine dut (
    .clk                  (clk),
    .rst                  (rst),
    .L5_en                (L5_en),
    .L4_read_addr         (L4_read_addr),
    .L4_read_data1        (d1),
    .L4_read_data2        (d2),
    .L5_weight_addra      (addra),
    .L5_weight_addrb      (addrb),
    .L5_weight_douta      (wa_dout),
    .L5_weight_doutb      (wb_dout),
    .L5_bias_addr         (bias_addr),
    .L5_bias_dout         (bias_dout),
    .L5_output_write_addr (wr_addr),
    .L5_output_write_data (wr_dat),
    .L5_output_wea        (wea),
    .neuron_count         (neuron_count),
    .L5_done              (L5_done)
  );

  always #5 clk = ~clk;

  // Memories: dout follows the registered address one clock later.
  always @(posedge clk) begin
    d1        <= 12'(f_val);
    d2        <= 12'(f_val);
    wa_dout   <= 12'(wa_val);
    wb_dout   <= 12'(wb_val);
    bias_dout <= bias_mem[bias_addr];
  end

  always @(negedge clk) begin
    if (wea) begin
      wr_data[wr_addr]  = wr_dat;
      wr_tag[wr_addr]   = run_id;
      wr_count[run_id]  = wr_count[run_id] + 1;
    end
    if (mon_en && neuron_count == 7'd5) begin
      if (addra >= 16'd2000 && addra <= 16'd2199) begin
        mon_idx = int'(addra) - 2000;
        addr_seen[mon_idx] = 1'b1;
        if (addrb != addra + 16'd200 || int'(L4_read_addr) != mon_idx)
          addr_bad = addr_bad + 1;
      end else if (!(addra == 16'd1799 && addrb == 16'd1999)) begin
        addr_bad = addr_bad + 1;
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_full(output int cyc);
    cyc = 0;
    @(negedge clk);
    L5_en = 1'b1;
    for (int k = 0; k < 30000; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (L5_done) break;
    end
  endtask

  // Drops L5_en inside the WRITE cycle of the n-th neuron of this run.
  task automatic wait_writes(input int run, input int n);
    for (int k = 0; k < 5000 && wr_count[run] < n; k++) begin
      @(negedge clk); #1;
    end
    L5_en = 1'b0;
    chk("writes_reached", wr_count[run], n);
  endtask

  task automatic check_done_drop();
    repeat (3) begin @(posedge clk); #1; end
    chk("done_held", L5_done, 1);
    @(negedge clk);
    L5_en = 1'b0;
    @(posedge clk); #1;
    chk("done_falls", L5_done, 0);
    chk("idle_ncnt_clear", neuron_count, 0);
  endtask

  initial begin
    int cyc, bad, s;
    rst = 1'b1;
    L5_en = 1'b0;
    for (int n = 0; n < 120; n++) bias_mem[n] = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", L5_done, 0);
    chk("rst_wea", wea, 0);
    chk("rst_l4addr", L4_read_addr, 0);
    chk("rst_addra", addra, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_ncnt", neuron_count, 0);
    rst = 1'b0;

    // Unity features, unit weights: 400 products of 1.0 * (1/64) each.
    run_id = 1; f_val = 64; wa_val = 1; wb_val = 1;
    run_full(cyc);
    chk("A_done_latency", cyc, 24721);
    chk("A_write_count", wr_count[1], 120);
    bad = 0;
    for (int n = 0; n < 120; n++) if (wr_tag[n] != 1 || wr_data[n] != 12'sd400) bad++;
    chk("A_bad_results", bad, 0);
    chk("A_result_0", wr_data[0], 400);
    chk("A_result_119", wr_data[119], 400);
    check_done_drop();

    // Positive overflow saturates.
    @(negedge clk);
    run_id = 2; wa_val = 64; wb_val = 64;
    L5_en = 1'b1;
    wait_writes(2, 2);
    chk("B_sat_pos_0", wr_data[0], 2047);
    chk("B_sat_pos_1", wr_data[1], 2047);
    repeat (10) @(negedge clk);
    chk("B_no_extra_writes", wr_count[2], 2);

    // Negative overflow saturates (or clamps to 0 with the fused ReLU).
    run_id = 3; wa_val = -64; wb_val = -64;
    L5_en = 1'b1;
    wait_writes(3, 2);
    chk("C_sat_neg_0", wr_data[0], EXP_NEG);
    chk("C_sat_neg_1", wr_data[1], EXP_NEG);

    // Zero features isolate the bias path; also watch neuron 5 addressing.
    repeat (3) @(negedge clk);
    run_id = 4; f_val = 0; wa_val = 1; wb_val = 1;
    for (int n = 0; n < 120; n++) bias_mem[n] = 12'(n);
    mon_en = 1'b1;
    run_full(cyc);
    mon_en = 1'b0;
    chk("D_done_latency", cyc, 24721);
    bad = 0;
    for (int n = 0; n < 120; n++) if (wr_tag[n] != 4 || wr_data[n] != 12'(n)) bad++;
    chk("D_bad_bias_results", bad, 0);
    chk("D_result_119", wr_data[119], 119);
    chk("D_n5_addr_bad", addr_bad, 0);
    s = 0;
    for (int i = 0; i < 200; i++) s += int'(addr_seen[i]);
    chk("D_n5_addr_span", s, 200);
    check_done_drop();

    // Reset in the middle of neuron 3's MAC, then restart with bank-2 weights doubled.
    for (int n = 0; n < 120; n++) bias_mem[n] = '0;
    @(negedge clk);
    run_id = 5; f_val = 64; wa_val = 1; wb_val = 2;
    L5_en = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (neuron_count == 7'd3 && L4_read_addr == 8'd100) break;
    end
    chk("E_abort_point_addra", addra, 1300);
    chk("E_pre_abort_writes", wr_count[5], 3);
    chk("E_pre_abort_result", wr_data[2], 600);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("E_abort_done", L5_done, 0);
    chk("E_abort_wea", wea, 0);
    chk("E_abort_ncnt", neuron_count, 0);
    chk("E_abort_addra", addra, 0);
    chk("E_abort_addrb", addrb, 0);
    chk("E_abort_l4addr", L4_read_addr, 0);
    chk("E_abort_wdata", wr_dat, 0);
    @(negedge clk);
    rst = 1'b0;
    L5_en = 1'b0;
    @(negedge clk);
    run_id = 6;
    L5_en = 1'b1;
    wait_writes(6, 8);
    repeat (20) @(negedge clk);
    chk("F_write_count", wr_count[6], 8);
    chk("F_no_neuron8_write", (wr_tag[8] == 6) ? 1 : 0, 0);
    chk("F_idle_after_drop", neuron_count, 0);
    bad = 0;
    for (int n = 0; n < 8; n++) if (wr_tag[n] != 6 || wr_data[n] != 12'sd600) bad++;
    chk("F_bad_results", bad, 0);
    chk("F_result_7", wr_data[7], 600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
